// File: rtl/npu_seq_pkg.sv
// Shared encodings and beat-count helpers for the NPU stream sequencer.
// Mode and FSM state encodings plus stream/row geometry functions.
package npu_seq_pkg;

  localparam logic [1:0] MODE_LOAD = 2'd0;
  localparam logic [1:0] MODE_EXEC = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_FINISH
  } state_t;

  function automatic int in_beats(int n, int dw, int aw);
    return (n * dw) / aw;
  endfunction

  function automatic int out_beats(int n, int acw, int aw);
    return (n * acw) / aw;
  endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// Exposes the head and the entry behind it for bubble-free draining.
module npu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign count  = r_cnt;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd];
  assign next   = r_mem[r_rd + AW'(1)];

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/npu_stream_sequencer.sv
// Streaming sequencer between DMA ports and the NxN systolic core.
// Packs input beats into rows, buffers results with credit flow control.
module npu_stream_sequencer
  import npu_seq_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int AXI_WIDTH  = 64,
  parameter int RES_DEPTH  = 32,
  parameter int ROW_CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ROW_CNT_W-1:0]    total_rows,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic [AXI_WIDTH-1:0]    dma_data_in,
  input  logic                    dma_data_in_valid,
  output logic                    dma_data_in_ready,
  output logic [AXI_WIDTH-1:0]    dma_data_out,
  output logic                    dma_data_out_valid,
  output logic                    dma_data_out_last,
  input  logic                    dma_data_out_ready,
  output logic                    core_load_weight,
  output logic [N-1:0]            core_valid_in,
  output logic [N*DATA_WIDTH-1:0] core_x_in,
  output logic [N*ACC_WIDTH-1:0]  core_y_in,
  input  logic [N*ACC_WIDTH-1:0]  core_y_out,
  input  logic [N-1:0]            core_valid_out
);

  localparam int XW        = N * DATA_WIDTH;
  localparam int YW        = N * ACC_WIDTH;
  localparam int IN_BEATS  = in_beats(N, DATA_WIDTH, AXI_WIDTH);
  localparam int OUT_BEATS = out_beats(N, ACC_WIDTH, AXI_WIDTH);
  localparam int IB_W      = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int OB_W      = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int FC_W      = $clog2(RES_DEPTH) + 1;

  if ((XW % AXI_WIDTH) != 0 || (YW % AXI_WIDTH) != 0 ||
      RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0)
  begin : g_bad_params
    $error("npu_stream_sequencer: illegal parameter set");
  end

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [ROW_CNT_W-1:0]  r_total;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [IB_W-1:0]       r_ibeat;
  logic [XW-1:0]         r_asm;
  logic                  r_cvalid;
  logic                  r_lw;
  logic [XW-1:0]         r_x;
  logic [ROW_CNT_W-1:0]  r_rows_fed;
  logic [ROW_CNT_W-1:0]  r_rows_drained;
  logic [FC_W-1:0]       r_inflight;
  logic [OB_W-1:0]       r_obeat;
  logic [AXI_WIDTH-1:0]  r_odata;
  logic                  r_ovalid;
  logic                  r_olast;

  logic [FC_W-1:0]       w_fcount;
  logic [YW-1:0]         w_fhead;
  logic [YW-1:0]         w_fnext;
  logic                  w_fempty;
  logic                  w_ffull;
  logic                  w_credit;
  logic                  w_last_ib;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_issue;
  logic                  w_cap;
  logic                  w_push;
  logic                  w_ofire;
  logic                  w_row_done;
  logic [XW-1:0]         w_asm;
  logic                  w_ld;
  logic [OB_W-1:0]       w_ld_beat;
  logic [YW-1:0]         w_ld_row;
  logic [ROW_CNT_W-1:0]  w_ld_idx;
  logic [AXI_WIDTH-1:0]  w_ld_data;
  logic                  w_ld_last;

  npu_sync_fifo #(
    .WIDTH (YW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (w_push),
    .push_data (core_y_out),
    .pop       (w_row_done),
    .head      (w_fhead),
    .next      (w_fnext),
    .empty     (w_fempty),
    .full      (w_ffull),
    .count     (w_fcount)
  );

  // A row may only be issued if its result is guaranteed a FIFO slot.
  assign w_credit   = ({1'b0, w_fcount} + {1'b0, r_inflight})
                      < (FC_W+1)'(RES_DEPTH);
  assign w_last_ib  = (r_ibeat == IB_W'(IN_BEATS - 1));
  assign w_in_ready = (r_state == S_FEED) && (!w_last_ib || w_credit);
  assign w_in_fire  = w_in_ready && dma_data_in_valid;
  assign w_issue    = w_in_fire && w_last_ib;
  assign w_cap      = (&core_valid_out) && (r_state != S_IDLE);
  assign w_push     = w_cap && !w_ffull;
  assign w_ofire    = r_ovalid && dma_data_out_ready;
  assign w_row_done = w_ofire && (r_obeat == OB_W'(OUT_BEATS - 1));

  always_comb begin
    w_asm = r_asm;
    w_asm[r_ibeat*AXI_WIDTH +: AXI_WIDTH] = dma_data_in;
  end

  // Next output beat: continue the head row, or jump to the following row.
  always_comb begin
    w_ld      = 1'b0;
    w_ld_beat = '0;
    w_ld_row  = w_fhead;
    w_ld_idx  = r_rows_drained;
    if (r_state != S_IDLE && (!r_ovalid || w_ofire)) begin
      if (w_row_done) begin
        w_ld_idx = r_rows_drained + ROW_CNT_W'(1);
        if (w_fcount >= FC_W'(2)) begin
          w_ld     = 1'b1;
          w_ld_row = w_fnext;
        end else if (w_fcount == FC_W'(1) && w_push) begin
          w_ld     = 1'b1;
          w_ld_row = core_y_out;
        end
      end else if (r_ovalid) begin
        w_ld      = 1'b1;
        w_ld_beat = r_obeat + OB_W'(1);
      end else if (!w_fempty) begin
        w_ld = 1'b1;
      end
    end
  end

  assign w_ld_data = w_ld_row[w_ld_beat*AXI_WIDTH +: AXI_WIDTH];
  assign w_ld_last = (w_ld_beat == OB_W'(OUT_BEATS - 1)) &&
                     (w_ld_idx == r_total - ROW_CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_mode         <= MODE_LOAD;
      r_total        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_ibeat        <= '0;
      r_asm          <= '0;
      r_cvalid       <= 1'b0;
      r_lw           <= 1'b0;
      r_x            <= '0;
      r_rows_fed     <= '0;
      r_rows_drained <= '0;
      r_inflight     <= '0;
      r_obeat        <= '0;
      r_odata        <= '0;
      r_ovalid       <= 1'b0;
      r_olast        <= 1'b0;
    end else if (abort) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_ibeat        <= '0;
      r_cvalid       <= 1'b0;
      r_lw           <= 1'b0;
      r_rows_fed     <= '0;
      r_rows_drained <= '0;
      r_inflight     <= '0;
      r_obeat        <= '0;
      r_ovalid       <= 1'b0;
      r_olast        <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_cvalid <= 1'b0;
      r_lw     <= 1'b0;

      if (w_cap && w_ffull) r_error <= 1'b1;
      r_inflight <= r_inflight
                    + FC_W'(w_issue && r_mode == MODE_EXEC)
                    - FC_W'(w_cap && r_inflight != '0);

      if (w_in_fire) begin
        r_asm <= w_asm;
        if (w_last_ib) begin
          r_ibeat    <= '0;
          r_x        <= w_asm;
          r_cvalid   <= 1'b1;
          r_lw       <= (r_mode == MODE_LOAD);
          r_rows_fed <= r_rows_fed + ROW_CNT_W'(1);
          if (r_rows_fed + ROW_CNT_W'(1) == r_total)
            r_state <= (r_mode == MODE_LOAD) ? S_FINISH : S_DRAIN;
        end else begin
          r_ibeat <= r_ibeat + IB_W'(1);
        end
      end

      if (w_ld) begin
        r_odata  <= w_ld_data;
        r_olast  <= w_ld_last;
        r_ovalid <= 1'b1;
        r_obeat  <= w_ld_beat;
      end else if (w_ofire) begin
        r_ovalid <= 1'b0;
        r_olast  <= 1'b0;
        r_obeat  <= '0;
      end
      if (w_row_done) r_rows_drained <= r_rows_drained + ROW_CNT_W'(1);

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode         <= mode;
            r_total        <= total_rows;
            r_error        <= 1'b0;
            r_rows_fed     <= '0;
            r_rows_drained <= '0;
            r_ibeat        <= '0;
            if (mode[1]) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
            end else if (total_rows == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_FEED;
              r_busy  <= 1'b1;
            end
          end
        end
        S_FEED: begin
        end
        S_DRAIN: begin
          if (r_rows_drained == r_total) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign error              = r_error;
  assign dma_data_in_ready  = w_in_ready;
  assign dma_data_out       = r_odata;
  assign dma_data_out_valid = r_ovalid;
  assign dma_data_out_last  = r_olast;
  assign core_load_weight   = r_lw;
  assign core_valid_in      = {N{r_cvalid}};
  assign core_x_in          = r_x;
  assign core_y_in          = '0;

endmodule
